// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter sharing one single-port on-chip RAM.
// Zero-latency grant; read data returns one cycle after accept.
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W / 8,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m0_read,
  input  logic              m1_read,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m0_waitrequest,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m0_readdatavalid,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0, req1;
  logic gnt0, gnt1;
  logic rd_acc;
  logic last_grant;
  logic rd_pend;
  logic rd_tag;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin favours the master that did not win last time.
  always_comb begin
    gnt0 = 1'b0;
    if (PRIO_MODE != 0)
      gnt0 = reset_n & req0;
    else
      gnt0 = reset_n & req0 & (~req1 | last_grant);
  end

  assign gnt1 = reset_n & req1 & ~gnt0;

  assign rd_acc = (gnt0 & m0_read & ~m0_write)
                | (gnt1 & m1_read & ~m1_write);

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_clken      = reset_n;

  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

  // Gating by reset_n drops a read whose data would land during reset.
  assign m0_readdatavalid = reset_n & rd_pend & ~rd_tag;
  assign m1_readdatavalid = reset_n & rd_pend & rd_tag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
    end else begin
      if (gnt0 | gnt1) begin
        last_grant <= gnt1;
        rd_tag     <= gnt1;
      end
      rd_pend <= rd_acc;
    end
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master arbiter that shares one single-port on-chip RAM (32-bit data, 13-bit word address, byte enables, one-cycle read latency) between two Avalon-MM requesters, e.g. CPU data master and a DMA master. It grants at most one transfer per cycle, routes write data and byte enables to the RAM, and returns read data with `readdatavalid` to the requester that issued the read. It sits between the interconnect masters and the RAM slave port.

## Interface
- `ADDR_W`, 13, word address width (8192 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byte-enable width (`DATA_W/8`)
- `PRIO_MODE`, 0, 0 = round-robin, 1 = fixed priority (m0 always wins)

- `clk`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `m0_address`, `m1_address`  in  ADDR_W  word address
- `m0_byteenable`, `m1_byteenable`  in  BE_W  byte lanes for writes
- `m0_read`, `m1_read`  in  1  read request
- `m0_write`, `m1_write`  in  1  write request
- `m0_writedata`, `m1_writedata`  in  DATA_W  write data
- `m0_waitrequest`, `m1_waitrequest`  out  1  high = request not accepted this cycle
- `m0_readdata`, `m1_readdata`  out  DATA_W  read data (both driven from `mem_readdata`)
- `m0_readdatavalid`, `m1_readdatavalid`  out  1  read data valid for that master
- `mem_address`  out  ADDR_W  RAM address
- `mem_byteenable`  out  BE_W  RAM byte enables
- `mem_chipselect`  out  1  RAM access this cycle
- `mem_write`  out  1  RAM write strobe
- `mem_writedata`  out  DATA_W  RAM write data
- `mem_clken`  out  1  RAM clock enable
- `mem_readdata`  in  DATA_W  RAM output, valid one cycle after address

## Operation
- Request from master k: `mk_read | mk_write`. Both high counts as a write; no `readdatavalid` is generated for it.
- Grant is decided combinationally each cycle from current requests plus registered `last_grant` (0 = m0, 1 = m1).
- Round-robin (`PRIO_MODE=0`): one requester → grant it; both → grant the one not equal to `last_grant`. `last_grant` updates only on a granted cycle.
- Fixed (`PRIO_MODE=1`): m0 wins whenever requesting; `last_grant` is still tracked but unused.
- Granted master: `waitrequest=0`; the other master, or a non-requesting master: `waitrequest=1`.
- Mem port muxed from granted master: `mem_chipselect=1`, `mem_write=write`, address, byteenable and writedata passed through. No grant → `mem_chipselect=0`, `mem_write=0`, other mem outputs hold the m0 mux value (don't-care).
- Read accepted in cycle N: registers `rd_pend=1`, `rd_tag=k`; in N+1, `mk_readdatavalid=1` with `mk_readdata=mem_readdata`; the other master's valid stays 0.
- `mem_clken` tied to 1 after reset; 0 while `reset_n=0`.
- No hazards: single port, accesses strictly in grant order; read after write to the same address in the next cycle returns new data (RAM behaviour).

## Timing
- Grant latency 0 cycles; read latency 1 cycle from accept to `readdatavalid`.
- Throughput 1 access/cycle; under continuous contention in round-robin mode grants alternate m0, m1, m0, …
- Reset values (`reset_n=0` at edge): `last_grant=1` (m0 wins first contention), `rd_pend=0`, `rd_tag=0`. While `reset_n=0`: both `waitrequest=1`, `mem_chipselect=0`, `mem_write=0`, `mem_clken=0`, both `readdatavalid=0`.
- Reset mid-operation: a read accepted in the cycle before reset asserts has its `readdatavalid` suppressed. It is lost, and masters must re-issue.
- Request deassertion while waiting is permitted; nothing is latched for unaccepted requests.

## Test plan
- Reset: hold `reset_n=0` 3 cycles with both masters requesting → both `waitrequest=1`, `mem_chipselect=0`, no valids; release → m0 granted first.
- Single master: m0 writes 0xDEADBEEF to 0x0010 with BE=0xF, then reads 0x0010 → `m0_waitrequest=0` both cycles, `m0_readdatavalid=1` one cycle after the read with 0xDEADBEEF, `m1_readdatavalid=0`.
- Byte lanes: m1 writes 0x000000AA with BE=0x1 over 0xDEADBEEF, then reads → 0xDEADBEAA returned on m1 only.
- Contention, round-robin: both read continuously from 0x0001 (m0) and 0x0002 (m1) for 6 cycles → grants m0, m1, m0, m1, m0, m1; each valid routed to the correct master one cycle later.
- `PRIO_MODE=1`: same stimulus → m0 granted all 6 cycles; `m1_waitrequest=1` throughout; m1 granted the first cycle m0 drops its request.
- Reset mid-read: m1 read accepted at cycle N, `reset_n=0` at N+1 → `m1_readdatavalid` stays 0.
